// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch
//  Purpose  : Instruction-fetch stage in front of the 8K x 17-bit instruction
//             memory. It owns the PC, drives the IM address and read enable,
//             and captures IM read data into the IF/ID register. It also
//             handles stall, redirect (flush) and HALT.
//  Ports    : clk, rst_n            - clock, asynchronous active-low reset
//             stall                 - hold PC and IF/ID
//             redirect, redirect_pc - one-cycle taken branch/jump and target
//             instr_in              - IM read data for the current im_addr
//             im_addr, im_rd_en     - IM address (the PC) and read enable
//             instr_id, pc_id       - IF/ID instruction and its PC+1
//             valid_id              - instr_id is a real instruction
//             halted                - fetch has stopped on HALT
//  Revision : 1.0  initial release
// ============================================================================
module instr_fetch #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [16:0] NOP_INSTR = 17'h0,
    parameter logic [4:0]  HALT_OP   = 5'h1F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic [16:0] instr_in,
    output logic [15:0] im_addr,
    output logic        im_rd_en,
    output logic [16:0] instr_id,
    output logic [15:0] pc_id,
    output logic        valid_id,
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_pc;
    logic [15:0] w_pc_nxt;
    logic [15:0] w_pc_inc;
    logic [16:0] r_instr_id;
    logic [16:0] w_instr_nxt;
    logic [15:0] r_pc_id;
    logic [15:0] w_pc_id_nxt;
    logic        r_valid_id;
    logic        w_valid_nxt;

    // 16-bit increment; wraps from 16'hFFFF to 16'h0000 naturally.
    assign w_pc_inc = r_pc + 16'd1;

    // State and IF/ID register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_PC;
            r_instr_id <= NOP_INSTR;
            r_pc_id    <= 16'h0000;
            r_valid_id <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_instr_id <= w_instr_nxt;
            r_pc_id    <= w_pc_id_nxt;
            r_valid_id <= w_valid_nxt;
        end
    end

    // Next-state logic. Everything holds unless a branch below changes it.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr_id;
        w_pc_id_nxt = r_pc_id;
        w_valid_nxt = r_valid_id;
        case (r_state)
            ST_BOOT: begin
                // The IM read of RESET_PC is in flight, so nothing is ready
                // to hand to decode yet. stall has no effect here.
                w_instr_nxt = NOP_INSTR;
                w_valid_nxt = 1'b0;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (redirect) begin
                    // The instruction now on instr_in is on the wrong path.
                    // Drop it, including a HALT, which must not take effect.
                    w_pc_nxt    = redirect_pc;
                    w_instr_nxt = NOP_INSTR;
                    w_valid_nxt = 1'b0;
                end else if (!stall) begin
                    w_instr_nxt = instr_in;
                    w_pc_id_nxt = w_pc_inc;
                    w_valid_nxt = 1'b1;
                    w_pc_nxt    = w_pc_inc;
                    if (instr_in[16:12] == HALT_OP) begin
                        w_state_nxt = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                // The PC stays frozen after the HALT instruction. Drain IF/ID
                // once downstream releases stall. Only reset leaves this state.
                if (!stall) begin
                    w_instr_nxt = NOP_INSTR;
                    w_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    assign im_addr  = r_pc;
    // BOOT always reads, because the first fetch must complete there even
    // if stall is asserted.
    assign im_rd_en = (r_state == ST_BOOT) || ((r_state == ST_RUN) && !stall);
    assign instr_id = r_instr_id;
    assign pc_id    = r_pc_id;
    assign valid_id = r_valid_id;
    assign halted   = (r_state == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch
//  Purpose  : Self-checking bench for instr_fetch. A behavioural IM reads on
//             negedge. Expected IF/ID contents are queued as stimulus is
//             applied and popped once per clock.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [16:0] instr_in;
    logic [15:0] im_addr;
    logic        im_rd_en;
    logic [16:0] instr_id;
    logic [15:0] pc_id;
    logic        valid_id;
    logic        halted;

    int checks = 0;
    int errors = 0;
    logic halt_en = 1'b0;

    typedef struct packed {
        logic        v;
        logic [16:0] i;
        logic [15:0] p;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    exp_t obs;

    instr_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_in    (instr_in),
        .im_addr     (im_addr),
        .im_rd_en    (im_rd_en),
        .instr_id    (instr_id),
        .pc_id       (pc_id),
        .valid_id    (valid_id),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // IM contents: 0x1000 ^ addr, which never decodes as HALT. A HALT is
    // placed at 0x0008 only while halt_en is set.
    function automatic logic [16:0] mem_val(input logic [15:0] a);
        if (halt_en && a == 16'h0008) return {5'h1F, 12'h008};
        return {1'b0, a ^ 16'h1000};
    endfunction

    initial instr_in = 17'h0;
    always @(negedge clk) if (im_rd_en) instr_in <= mem_val(im_addr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({valid_id, instr_id, pc_id, halted, im_addr} !== 51'h0) begin
            errors++;
            $display("FAIL reset_state got v=%0b i=%h p=%h h=%0b a=%h exp all zero",
                     valid_id, instr_id, pc_id, halted, im_addr);
        end
        checks++;
        if (im_rd_en !== 1'b1) begin
            errors++; $display("FAIL reset_rd_en got %0b exp 1", im_rd_en);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        sbq.push_back({1'b0, 17'h0, 16'h0});
        sbq.push_back({1'b1, 17'h01000, 16'h0001});
        sbq.push_back({1'b1, 17'h01001, 16'h0002});
        sbq.push_back({1'b1, 17'h01002, 16'h0003});
        for (int k = 0; k < 4; k++) begin
            step();
            e = sbq.pop_front();
            obs = {valid_id, instr_id, e.v ? pc_id : 16'h0};
            checks++;
            if (obs !== e) begin
                errors++; $display("FAIL seq[%0d] got %h exp %h", k, obs, e);
            end
        end
        checks++;
        if (im_addr !== 16'h0003 || im_rd_en !== 1'b1) begin
            errors++; $display("FAIL seq_addr got %h/%0b exp 0003/1", im_addr, im_rd_en);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        #1;
        checks++;
        if (im_rd_en !== 1'b0) begin
            errors++; $display("FAIL stall_rd_en got %0b exp 0", im_rd_en);
        end
        repeat (3) sbq.push_back({1'b1, 17'h01002, 16'h0003});
        for (int k = 0; k < 3; k++) begin
            step();
            e = sbq.pop_front();
            obs = {valid_id, instr_id, pc_id};
            checks++;
            if (obs !== e || im_addr !== 16'h0003) begin
                errors++; $display("FAIL stall_hold[%0d] got %h a=%h exp %h a=0003", k, obs, im_addr, e);
            end
        end
        stall = 1'b0;
        sbq.push_back({1'b1, 17'h01003, 16'h0004});
        sbq.push_back({1'b1, 17'h01004, 16'h0005});
        for (int k = 0; k < 2; k++) begin
            step();
            e = sbq.pop_front();
            obs = {valid_id, instr_id, pc_id};
            checks++;
            if (obs !== e) begin
                errors++; $display("FAIL stall_resume[%0d] got %h exp %h", k, obs, e);
            end
        end
    endtask

    task automatic test_redirect();
        redirect = 1'b1; redirect_pc = 16'h0040;
        sbq.push_back({1'b0, 17'h0, 16'h0});
        sbq.push_back({1'b1, 17'h01040, 16'h0041});
        step();
        redirect = 1'b0;
        e = sbq.pop_front();
        obs = {valid_id, instr_id, 16'h0};
        checks++;
        if (obs !== e || im_addr !== 16'h0040) begin
            errors++; $display("FAIL redir_bubble got %h a=%h exp %h a=0040", obs, im_addr, e);
        end
        step();
        e = sbq.pop_front();
        obs = {valid_id, instr_id, pc_id};
        checks++;
        if (obs !== e) begin
            errors++; $display("FAIL redir_target got %h exp %h", obs, e);
        end
    endtask

    task automatic test_redirect_stall();
        redirect = 1'b1; stall = 1'b1; redirect_pc = 16'h0080;
        sbq.push_back({1'b0, 17'h0, 16'h0});
        sbq.push_back({1'b1, 17'h01080, 16'h0081});
        step();
        redirect = 1'b0; stall = 1'b0;
        e = sbq.pop_front();
        obs = {valid_id, instr_id, 16'h0};
        checks++;
        if (obs !== e || im_addr !== 16'h0080) begin
            errors++; $display("FAIL rs_bubble got %h a=%h exp %h a=0080", obs, im_addr, e);
        end
        step();
        e = sbq.pop_front();
        obs = {valid_id, instr_id, pc_id};
        checks++;
        if (obs !== e) begin
            errors++; $display("FAIL rs_target got %h exp %h", obs, e);
        end
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        sbq.push_back({1'b0, 17'h0, 16'h0});
        sbq.push_back({1'b1, 17'h0EFFF, 16'h0000});
        sbq.push_back({1'b1, 17'h01000, 16'h0001});
        step();
        redirect = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) step();
            e = sbq.pop_front();
            obs = {valid_id, instr_id, e.v ? pc_id : 16'h0};
            checks++;
            if (obs !== e) begin
                errors++; $display("FAIL wrap[%0d] got %h exp %h", k, obs, e);
            end
            if (k == 1) begin
                checks++;
                if (im_addr !== 16'h0000) begin
                    errors++; $display("FAIL wrap_addr got %h exp 0000", im_addr);
                end
            end
        end
    endtask

    task automatic test_halt();
        halt_en = 1'b1;
        // First, a redirect arriving in the same cycle the HALT is captured
        // must win, so fetch does not halt.
        redirect = 1'b1; redirect_pc = 16'h0007;
        step();
        redirect = 1'b0;
        step();
        checks++;
        if ({valid_id, instr_id, pc_id} !== {1'b1, 17'h01007, 16'h0008}) begin
            errors++; $display("FAIL halt_pre got %0b %h %h exp 1 01007 0008", valid_id, instr_id, pc_id);
        end
        redirect = 1'b1; redirect_pc = 16'h0020;
        step();
        redirect = 1'b0;
        checks++;
        if (halted !== 1'b0 || valid_id !== 1'b0 || im_addr !== 16'h0020) begin
            errors++; $display("FAIL halt_redir_wins got h=%0b v=%0b a=%h exp 0 0 0020", halted, valid_id, im_addr);
        end
        // Now let the HALT through.
        redirect = 1'b1; redirect_pc = 16'h0008;
        step();
        redirect = 1'b0;
        sbq.push_back({1'b1, 17'h1F008, 16'h0009});
        sbq.push_back({1'b1, 17'h1F008, 16'h0009});
        step();
        e = sbq.pop_front();
        obs = {valid_id, instr_id, pc_id};
        checks++;
        if (obs !== e || halted !== 1'b1 || im_rd_en !== 1'b0 || im_addr !== 16'h0009) begin
            errors++; $display("FAIL halt_capture got %h h=%0b en=%0b a=%h exp %h 1 0 0009",
                               obs, halted, im_rd_en, im_addr, e);
        end
        stall = 1'b1;
        step();
        stall = 1'b0;
        e = sbq.pop_front();
        obs = {valid_id, instr_id, pc_id};
        checks++;
        if (obs !== e) begin
            errors++; $display("FAIL halt_stall_hold got %h exp %h", obs, e);
        end
        redirect = 1'b1; redirect_pc = 16'h0040;
        step();
        redirect = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (valid_id !== 1'b0 || halted !== 1'b1 || im_addr !== 16'h0009 || im_rd_en !== 1'b0) begin
                errors++; $display("FAIL halt_frozen[%0d] got v=%0b h=%0b a=%h en=%0b exp 0 1 0009 0",
                                   k, valid_id, halted, im_addr, im_rd_en);
            end
            step();
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (im_addr !== 16'h0000 || halted !== 1'b0 || valid_id !== 1'b0) begin
            errors++; $display("FAIL halt_reset got a=%h h=%0b v=%0b exp 0000 0 0", im_addr, halted, valid_id);
        end
        @(negedge clk);
        rst_n = 1'b1;
        halt_en = 1'b0;
        step();
        step();
        checks++;
        if ({valid_id, instr_id, pc_id} !== {1'b1, 17'h01000, 16'h0001}) begin
            errors++; $display("FAIL halt_restart got %0b %h %h exp 1 01000 0001", valid_id, instr_id, pc_id);
        end
    endtask

    task automatic test_async_reset();
        stall = 1'b1;
        repeat (2) step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({valid_id, instr_id, pc_id, halted, im_addr} !== 51'h0) begin
            errors++; $display("FAIL async_reset got v=%0b i=%h p=%h h=%0b a=%h exp all zero",
                               valid_id, instr_id, pc_id, halted, im_addr);
        end
        @(negedge clk);
        stall = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap();
        test_halt();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
